// File: rtl/ppm_pkg.sv
// Shared types and helpers for the PPM throttle transmitter.
package ppm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEP,
    CH,
    SYNC_SEP,
    SYNC_GAP
  } ppm_state_t;

  typedef logic [14:0] us_t;

  function automatic logic [11:0] slot_width(input logic [7:0] v, input logic [11:0] min_us);
    return min_us + {2'b00, v, 2'b00};
  endfunction

endpackage

// File: rtl/ppm_tick_gen.sv
// Microsecond tick divider: one-cycle pulse every CLK_HZ/1_000_000 clocks.
module ppm_tick_gen #(
  parameter int unsigned CLK_HZ = 65_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic o_tick
);

  localparam int unsigned DIV = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      o_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ppm_throttle_tx.sv
// PPM frame transmitter: latches throttle + aux channels once per frame and
// serializes them as low separators + high slots. Optional throttle slew: PPM_SLEW_EN.
module ppm_throttle_tx
  import ppm_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 65_000_000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned FRAME_US  = 20000,
  parameter int unsigned PULSE_US  = 400,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned SLEW_STEP = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    on,
  input  logic [7:0]              hover,
  input  logic [8*(NUM_CH-1)-1:0] ch_aux,
  output logic                    ppm,
  output logic                    frame_start,
  output logic                    busy
);

  localparam int unsigned   CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [11:0]   PULSE_W = 12'(PULSE_US);
  localparam logic [11:0]   MIN_W   = 12'(MIN_US);
  localparam us_t           FRAME_W = us_t'(FRAME_US);

  logic        w_tick;
  logic        w_latch;
  logic [7:0]  w_thr_next;
  logic [11:0] w_slot_nx;
  logic [11:0] w_slot_end;
  us_t         w_us_nx;

  ppm_state_t  r_state;
  us_t         r_us_cnt;
  logic [11:0] r_slot_cnt;
  logic [CW-1:0] r_ch_idx;
  logic [7:0]  r_shadow [NUM_CH];
  logic        r_ppm;
  logic        r_frame_start;

  ppm_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign w_us_nx    = r_us_cnt + 1'b1;
  assign w_slot_nx  = r_slot_cnt + 12'd1;
  assign w_slot_end = slot_width(r_shadow[r_ch_idx], MIN_W);
  assign w_latch    = w_tick && ((r_state == IDLE) ||
                                 ((r_state == SYNC_GAP) && (w_us_nx == FRAME_W)));

`ifdef PPM_SLEW_EN
  localparam logic [7:0] STEP_W = (SLEW_STEP > 255) ? 8'd255 : 8'(SLEW_STEP);
  logic [7:0] r_slew;

  // Differences are compared before stepping so the 8-bit sum never wraps.
  always_comb begin
    w_thr_next = r_slew;
    if (!on)
      w_thr_next = '0;
    else if (hover > r_slew)
      w_thr_next = ((hover - r_slew) > STEP_W) ? r_slew + STEP_W : hover;
    else if (hover < r_slew)
      w_thr_next = ((r_slew - hover) > STEP_W) ? r_slew - STEP_W : hover;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_slew <= '0;
    else if (w_latch) r_slew <= w_thr_next;
  end
`else
  assign w_thr_next = on ? hover : '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_us_cnt      <= '0;
      r_slot_cnt    <= '0;
      r_ch_idx      <= '0;
      r_ppm         <= 1'b1;
      r_frame_start <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_latch) begin
        r_state       <= SEP;
        r_us_cnt      <= '0;
        r_slot_cnt    <= '0;
        r_ch_idx      <= '0;
        r_ppm         <= 1'b0;
        r_frame_start <= 1'b1;
        r_shadow[0]   <= w_thr_next;
        for (int unsigned k = 1; k < NUM_CH; k++) r_shadow[k] <= ch_aux[8*k-8 +: 8];
      end else if (w_tick) begin
        r_us_cnt   <= w_us_nx;
        r_slot_cnt <= w_slot_nx;
        case (r_state)
          SEP: if (w_slot_nx == PULSE_W) begin
            r_state <= CH;
            r_ppm   <= 1'b1;
          end
          // Slot count runs from the start of the separator, so it resets here.
          CH: if (w_slot_nx == w_slot_end) begin
            r_slot_cnt <= '0;
            r_ppm      <= 1'b0;
            if (r_ch_idx == LAST_CH) begin
              r_state <= SYNC_SEP;
            end else begin
              r_ch_idx <= r_ch_idx + 1'b1;
              r_state  <= SEP;
            end
          end
          SYNC_SEP: if (w_slot_nx == PULSE_W) begin
            r_state <= SYNC_GAP;
            r_ppm   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ppm         = r_ppm;
  assign frame_start = r_frame_start;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ppm_throttle_tx.sv
// Scoreboard bench for ppm_throttle_tx with scaled timing (2 clocks per us).
module tb_ppm_throttle_tx;

  localparam int unsigned CLK_HZ    = 2_000_000;
  localparam int unsigned DIV       = 2;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned FRAME_US  = 5000;
  localparam int unsigned PULSE_US  = 50;
  localparam int unsigned MIN_US    = 200;
  localparam int unsigned SLEW_STEP = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic on    = 1'b0;
  logic [7:0] hover = '0;
  logic [8*(NUM_CH-1)-1:0] ch_aux = '0;
  logic ppm, frame_start, busy;

  typedef struct {
    int   t;
    logic lvl;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  exp_slew = 0;

  ppm_throttle_tx #(
    .CLK_HZ   (CLK_HZ),
    .NUM_CH   (NUM_CH),
    .FRAME_US (FRAME_US),
    .PULSE_US (PULSE_US),
    .MIN_US   (MIN_US),
    .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .on         (on),
    .hover      (hover),
    .ch_aux     (ch_aux),
    .ppm        (ppm),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic int slot_us(input int v);
    return MIN_US + v * 4;
  endfunction

  // Expected throttle value the DUT should latch at the coming frame start.
  task automatic model_latch(output int thr);
    if (!on) begin
      thr = 0;
      exp_slew = 0;
    end else begin
`ifdef PPM_SLEW_EN
      if (int'(hover) > exp_slew)
        exp_slew = (int'(hover) - exp_slew > SLEW_STEP) ? exp_slew + SLEW_STEP : int'(hover);
      else if (int'(hover) < exp_slew)
        exp_slew = (exp_slew - int'(hover) > SLEW_STEP) ? exp_slew - SLEW_STEP : int'(hover);
      thr = exp_slew;
`else
      thr = int'(hover);
`endif
    end
  endtask

  // Push the ppm edges (in us from frame start) for one frame.
  task automatic push_frame(input int thr);
    int pos = 0;
    int v;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k == 0) v = thr;
      else        v = int'(ch_aux[8*k-8 +: 8]);
      if (k > 0) exp_q.push_back('{pos, 1'b0});
      exp_q.push_back('{pos + PULSE_US, 1'b1});
      pos += slot_us(v);
    end
    exp_q.push_back('{pos, 1'b0});
    exp_q.push_back('{pos + PULSE_US, 1'b1});
  endtask

  task automatic wait_frame_start(input string name, input int max_cycles, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (frame_start === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_frame_start: not seen within %0d cycles (required)", name, max_cycles);
    end
  endtask

  task automatic observe_frame(input string name, input int max_wait,
                               input int mid_us, input logic [7:0] mid_hover);
    bit   ok;
    bit   saw_fs = 0;
    logic prev;
    ev_t  e;
    wait_frame_start(name, max_wait, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    checks++;
    if (ppm !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_start_outputs: ppm=%b busy=%b required ppm=0 busy=1", name, ppm, busy);
    end
    prev = ppm;
    for (int n = 1; n < int'(FRAME_US * DIV); n++) begin
      @(negedge clock);
      if (n == mid_us * int'(DIV)) hover = mid_hover;
      if (frame_start !== 1'b0) saw_fs = 1;
      if (ppm !== prev) begin
        prev = ppm;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_edge: unexpected ppm=%b at cycle %0d, required no edge", name, ppm, n);
        end else begin
          e = exp_q.pop_front();
          if (n != e.t * int'(DIV) || ppm !== e.lvl) begin
            failures++;
            $display("FAIL %s_edge: ppm=%b at cycle %0d, required ppm=%b at cycle %0d",
                     name, ppm, n, e.lvl, e.t * int'(DIV));
          end
        end
      end
    end
    checks++;
    if (saw_fs) begin
      failures++;
      $display("FAIL %s_frame_start_mid: frame_start=1 inside frame, required 0", name);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_edges: %0d edges not seen, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    int thr;
    reset = 1'b0; on = 1'b1; hover = 8'd0; ch_aux = '0;
    exp_slew = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (ppm !== 1'b1) begin
      failures++; $display("FAIL reset_ppm: ppm=%b required 1", ppm);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: busy=%b required 0", busy);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      failures++; $display("FAIL reset_frame_start: frame_start=%b required 0", frame_start);
    end
    reset = 1'b1;
    model_latch(thr);
    push_frame(thr);
    observe_frame("zero_frame", DIV + 3, -1, 8'd0);
  endtask

  task automatic test_hover_128();
    int thr;
    hover = 8'd128;
    model_latch(thr);
    push_frame(thr);
    observe_frame("hover128", 1, -1, 8'd0);
  endtask

  task automatic test_mid_frame_change();
    int thr;
    hover = 8'd0;
    model_latch(thr);
    push_frame(thr);
    observe_frame("mid_change_cur", 1, 100, 8'd255);
    ch_aux = {8'd10, 8'd50, 8'd3};
    model_latch(thr);
    push_frame(thr);
    observe_frame("mid_change_next", 1, -1, 8'd0);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int thr;
    wait_frame_start("pre_reset", 1, ok);
    repeat (PULSE_US * DIV + 20) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ppm !== 1'b1 || busy !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: ppm=%b busy=%b frame_start=%b required 1 0 0",
               ppm, busy, frame_start);
    end
    on = 1'b0; hover = 8'd200; ch_aux = {8'd0, 8'd0, 8'd50};
    exp_slew = 0;
    @(negedge clock);
    reset = 1'b1;
    model_latch(thr);
    push_frame(thr);
    observe_frame("off_after_reset", DIV + 3, -1, 8'd0);
  endtask

  initial begin
    test_reset();
    test_hover_128();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppm_throttle_tx.md
# ppm_throttle_tx

Pulse-position-modulation (PPM) frame transmitter on the drone-command output path. It takes the 8-bit `hover` throttle command and the auxiliary channel bytes and serializes them into a standard RC trainer-port PPM stream that drives the handheld transmitter. Channel values are latched once per frame, and an optional slew limiter smooths throttle steps.

## Interface
- `CLK_HZ`, 65_000_000, system clock frequency; the microsecond tick divisor is CLK_HZ/1_000_000.
- `NUM_CH`, 4, channels per frame; channel 0 is throttle.
- `FRAME_US`, 20000, total frame period in µs; must be ≤ 32767.
- `PULSE_US`, 400, width of the low separator pulse in µs.
- `MIN_US`, 1000, channel slot width for value 0.
- `SLEW_STEP`, 16, maximum throttle change per frame. Used only with `PPM_SLEW_EN`.

- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `on`  in  1  arm; when low, the latched throttle is forced to 0.
- `hover`  in  8  throttle command for channel 0.
- `ch_aux`  in  8*(NUM_CH-1)  channels 1..NUM_CH-1; channel k occupies bits [8k-1:8k-8].
- `ppm`  out  1  PPM stream; idles high, separators are driven low.
- `frame_start`  out  1  one-cycle pulse in the cycle the channel values are latched.
- `busy`  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- **Tick generator:** the µs tick is a one-cycle pulse every CLK_HZ/1_000_000 clocks. All pulse and slot timing counts ticks.
- **Slot width:** MIN_US + (value << 2). This gives a range of 1000–2020 µs. Slot arithmetic is 12 bits, and the frame counter `us_cnt` is 15 bits.
- **FSM states:** IDLE, SEP, CH, SYNC_SEP, SYNC_GAP.
- **IDLE → SEP:** taken on the first tick after reset release. This transition latches all channels into shadow registers and pulses `frame_start`. It also clears `us_cnt` and sets `ch_idx` = 0.
- **SEP:** `ppm` = 0 for PULSE_US ticks, then go to CH.
- **CH:** `ppm` = 1 until the slot tick count (counted from the start of SEP) reaches the slot width of `ch_idx`.
  - If `ch_idx` < NUM_CH-1: increment `ch_idx` and go to SEP.
  - Otherwise: go to SYNC_SEP.
- **SYNC_SEP:** `ppm` = 0 for PULSE_US ticks, then go to SYNC_GAP.
- **SYNC_GAP:** `ppm` = 1 until `us_cnt` reaches FRAME_US. Then latch, pulse `frame_start`, and go directly to SEP (new frame). IDLE is entered only from reset.
- **Latching:** inputs are sampled only at frame start. Input changes mid-frame affect the next frame only.
- **Throttle latch:** if `on` = 0, the shadow throttle is 0. Otherwise it is `hover` (or the slewed value, see Configuration).
- **Reset mid-frame:** `ppm` goes to 1 and `busy` and `frame_start` go to 0 immediately (asynchronously). The shadow registers and slewed throttle clear to 0, and a fresh frame begins after release.

## Timing
- **Reset values:** `ppm` = 1, `frame_start` = 0, `busy` = 0, state IDLE, shadows = 0.
- **Output registering:** `ppm` is registered and changes one clock after the tick that ends a phase. Phase boundaries are exact to the tick; tick jitter is 0.
- **Frame period:** FRAME_US µs exactly. The sync gap absorbs the variable channel total; with the worst case NUM_CH = 4, the channels use 8080 µs, leaving ≥ 11920 µs.
- **`frame_start`:** asserted in the same cycle the shadows load. `busy` rises in that same cycle.

## Configuration
- **`PPM_SLEW_EN` defined:** the slewed throttle register moves toward `hover` by at most SLEW_STEP per frame, saturating at the target. `on` = 0 bypasses the slew and forces 0 immediately.
- **`PPM_SLEW_EN` undefined:** `hover` is latched directly. The SLEW_STEP parameter is ignored, and no slew register is present.

## Structure
- **Shared package `ppm_pkg`:** the FSM state enum `ppm_state_t`, the slot-width function (MIN_US + (v<<2)), and the 15-bit `us_t` counter typedef.
- **Sub-module `ppm_tick_gen`:** the µs tick divider, parameterized by CLK_HZ, with the same `clock`/`reset` ports.

## Test plan
- Reset release, `on` = 1, `hover` = 0, `ch_aux` = 0 → `ppm` low pulses of 400 µs start at t = 0, 1000, 2000, 3000, 4000 µs. The next frame starts at 20000 µs.
- `hover` = 128 → the channel-0 slot is 1512 µs, so channel 1's separator starts at 1512 µs.
- `hover` changes 0→255 at 500 µs into a frame → the current frame's slot stays 1000 µs, and the next frame's slot is 2020 µs.
- `on` = 0, `hover` = 200, `ch_aux` channel 1 = 50 → the channel-0 slot is 1000 µs and the channel-1 slot is 1200 µs.
- `PPM_SLEW_EN`, SLEW_STEP = 16, `hover` steps 0→255 → the channel-0 slot grows by 64 µs per frame and reaches 2020 µs in the 16th frame.
- `reset` asserted during CH → `ppm` = 1 and `busy` = 0 within the same cycle. After release, the first `frame_start` follows the first tick, with the throttle shadow at 0 if `on` was low at that tick.
